// File: rtl/ad9361_spi_sequencer_if.sv
// Requester, response and SPI-core register-port signals of the AD9361 SPI sequencer.
// The master modport is the sequencer; the slave modport is the fabric plus SPI core side.
interface ad9361_spi_sequencer_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_write;
    logic [19:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_ack;
    logic        rsp_valid;
    logic        rsp_id;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic        spi_select;
    logic        spi_read_n;
    logic        spi_write_n;
    logic [2:0]  spi_mem_addr;
    logic [15:0] spi_data_from_cpu;
    logic [15:0] spi_data_to_cpu;
    logic        spi_readyfordata;
    logic        spi_dataavailable;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        input  spi_data_to_cpu, spi_readyfordata, spi_dataavailable,
        output req_ack, rsp_valid, rsp_id, rsp_rdata, rsp_err, busy,
        output spi_select, spi_read_n, spi_write_n, spi_mem_addr, spi_data_from_cpu
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        output spi_data_to_cpu, spi_readyfordata, spi_dataavailable,
        input  req_ack, rsp_valid, rsp_id, rsp_rdata, rsp_err, busy,
        input  spi_select, spi_read_n, spi_write_n, spi_mem_addr, spi_data_from_cpu
    );
endinterface

// File: rtl/ad9361_spi_sequencer.sv
// Round-robin sequencer turning AD9361 register requests into SPI-core register-port
// transactions: select, SSO on, three byte write/read pairs, SSO off, response.
//
// state     | meaning
// IDLE      | arbitrate between requesters
// GRANT     | req_ack pulse, transaction fields already latched
// SEL       | write slave-select register (addr5)
// SSO_ON    | force slave select active (addr3 = 0x0400)
// WAIT_TX   | wait for readyfordata
// WR_DATA   | write tx byte (addr1)
// WAIT_RX   | wait for dataavailable
// RD_DATA   | read rx byte (addr0)
// ABORT     | clear core status after timeout (addr2)
// SSO_OFF   | release slave select (addr3 = 0)
// RESP      | rsp_valid pulse
module ad9361_spi_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [15:0] SS_MASK        = 16'h0001
) (
    input  logic                       clk,
    input  logic                       reset_n,
    ad9361_spi_sequencer_if.master     bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_GRANT, S_SEL, S_SSO_ON, S_WAIT_TX, S_WR_DATA,
        S_WAIT_RX, S_RD_DATA, S_ABORT, S_SSO_OFF, S_RESP
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state, state_nxt;
    logic [1:0] phase;
    logic [1:0] byte_idx;
    logic [7:0] wait_cnt;
    logic       last_grant;
    logic       cur_id;
    logic       cur_write;
    logic [9:0] cur_addr;
    logic [7:0] cur_wdata;
    logic [7:0] rx_byte;
    logic       err;

    logic       any_valid;
    logic       grant_id;
    logic       is_access;
    logic       acc_active;
    logic       acc_done;
    logic       timed_out;
    logic [7:0] tx_byte;
    logic       unused_hi;

    assign unused_hi = ^bus.spi_data_to_cpu[15:8];

    assign any_valid = |bus.req_valid;
    always_comb begin
        grant_id = 1'b0;
        if (bus.req_valid == 2'b11) grant_id = ~last_grant;
        else if (bus.req_valid[1]) grant_id = 1'b1;
    end

    assign is_access  = (state == S_SEL) || (state == S_SSO_ON) || (state == S_WR_DATA) ||
                        (state == S_RD_DATA) || (state == S_ABORT) || (state == S_SSO_OFF);
    // phase 0/1 drive the access, phase 2 is the mandatory idle gap
    assign acc_active = is_access && (phase != 2'd2);
    assign acc_done   = is_access && (phase == 2'd2);
    assign timed_out  = (wait_cnt == TO_LAST);

    always_comb begin
        tx_byte = 8'h00;
        case (byte_idx)
            2'd0:    tx_byte = {cur_write, 5'b00000, cur_addr[9:8]};
            2'd1:    tx_byte = cur_addr[7:0];
            default: tx_byte = cur_write ? cur_wdata : 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            phase      <= 2'd0;
            byte_idx   <= 2'd0;
            wait_cnt   <= 8'd0;
            last_grant <= 1'b1;
            cur_id     <= 1'b0;
            cur_write  <= 1'b0;
            cur_addr   <= 10'd0;
            cur_wdata  <= 8'd0;
            rx_byte    <= 8'd0;
            err        <= 1'b0;
        end else begin
            state    <= state_nxt;
            phase    <= acc_active ? phase + 2'd1 : 2'd0;
            wait_cnt <= ((state == S_WAIT_TX) || (state == S_WAIT_RX)) ? wait_cnt + 8'd1 : 8'd0;
            if ((state == S_IDLE) && any_valid) begin
                cur_id     <= grant_id;
                last_grant <= grant_id;
                cur_write  <= bus.req_write[grant_id];
                cur_addr   <= grant_id ? bus.req_addr[19:10] : bus.req_addr[9:0];
                cur_wdata  <= grant_id ? bus.req_wdata[15:8] : bus.req_wdata[7:0];
                byte_idx   <= 2'd0;
                rx_byte    <= 8'd0;
                err        <= 1'b0;
            end
            if ((state == S_RD_DATA) && (phase == 2'd1)) rx_byte <= bus.spi_data_to_cpu[7:0];
            if ((state == S_RD_DATA) && (phase == 2'd2)) byte_idx <= byte_idx + 2'd1;
            if (state == S_ABORT) err <= 1'b1;
        end
    end

    always_comb begin
        state_nxt             = state;
        bus.req_ack           = 2'b00;
        bus.rsp_valid         = 1'b0;
        bus.rsp_id            = 1'b0;
        bus.rsp_rdata         = 8'h00;
        bus.rsp_err           = 1'b0;
        bus.busy              = (state != S_IDLE);
        bus.spi_select        = 1'b0;
        bus.spi_read_n        = 1'b1;
        bus.spi_write_n       = 1'b1;
        bus.spi_mem_addr      = 3'd0;
        bus.spi_data_from_cpu = 16'h0000;

        case (state)
            S_IDLE:    if (any_valid) state_nxt = S_GRANT;
            S_GRANT: begin
                bus.req_ack[cur_id] = 1'b1;
                state_nxt = S_SEL;
            end
            S_SEL:     if (acc_done) state_nxt = S_SSO_ON;
            S_SSO_ON:  if (acc_done) state_nxt = S_WAIT_TX;
            S_WAIT_TX: begin
                if (bus.spi_readyfordata) state_nxt = S_WR_DATA;
                else if (timed_out)       state_nxt = S_ABORT;
            end
            S_WR_DATA: if (acc_done) state_nxt = S_WAIT_RX;
            S_WAIT_RX: begin
                if (bus.spi_dataavailable) state_nxt = S_RD_DATA;
                else if (timed_out)        state_nxt = S_ABORT;
            end
            S_RD_DATA: if (acc_done) state_nxt = (byte_idx == 2'd2) ? S_SSO_OFF : S_WAIT_TX;
            S_ABORT:   if (acc_done) state_nxt = S_SSO_OFF;
            S_SSO_OFF: if (acc_done) state_nxt = S_RESP;
            S_RESP: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_id    = cur_id;
                bus.rsp_err   = err;
                bus.rsp_rdata = (cur_write || err) ? 8'h00 : rx_byte;
                state_nxt     = S_IDLE;
            end
            default:   state_nxt = S_IDLE;
        endcase

        if (acc_active) begin
            bus.spi_select = 1'b1;
            case (state)
                S_SEL: begin
                    bus.spi_mem_addr      = 3'd5;
                    bus.spi_data_from_cpu = SS_MASK;
                    bus.spi_write_n       = 1'b0;
                end
                S_SSO_ON: begin
                    bus.spi_mem_addr      = 3'd3;
                    bus.spi_data_from_cpu = 16'h0400;
                    bus.spi_write_n       = 1'b0;
                end
                S_WR_DATA: begin
                    bus.spi_mem_addr      = 3'd1;
                    bus.spi_data_from_cpu = {8'h00, tx_byte};
                    bus.spi_write_n       = 1'b0;
                end
                S_RD_DATA: begin
                    bus.spi_mem_addr      = 3'd0;
                    bus.spi_read_n        = 1'b0;
                end
                S_ABORT: begin
                    bus.spi_mem_addr      = 3'd2;
                    bus.spi_write_n       = 1'b0;
                end
                default: begin
                    bus.spi_mem_addr      = 3'd3;
                    bus.spi_write_n       = 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ad9361_spi_sequencer.sv
// Scoreboard bench for ad9361_spi_sequencer with a behavioural SPI-core register model.
module tb_ad9361_spi_sequencer;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    ad9361_spi_sequencer_if bus();

    ad9361_spi_sequencer #(.TIMEOUT_CYCLES(16), .SS_MASK(16'h0001)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    typedef struct { bit rd; logic [2:0] a; logic [15:0] d; } acc_t;
    typedef struct { bit id; logic [7:0] rdata; bit err; } rsp_t;
    acc_t exp_acc[$];
    rsp_t exp_rsp[$];
    bit   exp_grant[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input string detail);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: %s", name, detail);
    endtask

    // SPI core model: TX byte shifts for 16 sys clocks, then RRDY/TRDY rise
    logic       trdy, rrdy;
    logic [7:0] rx_reg;
    logic [7:0] miso2 = 8'h5C;
    logic [15:0] sso_reg = 16'h0;
    int shift_cnt, byte_n, m_idx, w2_cyc;
    int stall_byte = 3;
    int w1_cyc[3];
    bit m_prev_sel;
    assign bus.spi_readyfordata  = trdy;
    assign bus.spi_dataavailable = rrdy;
    assign bus.spi_data_to_cpu   = {8'h00, rx_reg};

    always @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trdy = 1'b1; rrdy = 1'b0; rx_reg = 8'h00; shift_cnt = 0;
            byte_n = 0; m_idx = 0; m_prev_sel = 1'b0;
        end else begin
            if (shift_cnt > 0) begin
                shift_cnt--;
                if (shift_cnt == 0) begin
                    trdy = 1'b1;
                    rx_reg = (m_idx == 0) ? 8'hC3 : (m_idx == 1) ? 8'h3C : miso2;
                    if (m_idx != stall_byte) rrdy = 1'b1;
                end
            end
            if (bus.spi_select && !m_prev_sel && !bus.spi_write_n) begin
                if (bus.spi_mem_addr == 3'd1) begin
                    check(trdy, "toe", $sformatf("write to addr1 with readyfordata=%0d, want 1", trdy));
                    m_idx = byte_n;
                    if (byte_n < 3) w1_cyc[byte_n] = cyc;
                    byte_n++;
                    trdy = 1'b0;
                    shift_cnt = 16;
                end
                if (bus.spi_mem_addr == 3'd3) begin
                    sso_reg = bus.spi_data_from_cpu;
                    if (bus.spi_data_from_cpu == 16'h0400) byte_n = 0;
                end
                if (bus.spi_mem_addr == 3'd2) begin
                    rrdy = 1'b0; trdy = 1'b1; shift_cnt = 0; w2_cyc = cyc;
                end
            end
            if (bus.spi_select && m_prev_sel && !bus.spi_read_n && bus.spi_mem_addr == 3'd0) rrdy = 1'b0;
            m_prev_sel = bus.spi_select;
        end
    end

    // monitors: bus accesses, grants, responses
    bit b_prev_sel, b_rd, b_ok, idle_bad = 1'b0;
    logic [2:0] b_a;
    logic [15:0] b_d;
    int b_len, ack_cyc = 0, n_rsp = 0, n_acks = 0;
    logic [1:0] a_prev;
    always @(negedge clk) begin
        acc_t e;
        rsp_t r;
        bit   g;
        if (!reset_n) begin
            b_prev_sel = 1'b0; b_len = 0; a_prev = 2'b00;
        end else begin
            if (bus.spi_select) begin
                if (!b_prev_sel) begin
                    b_len = 1; b_rd = !bus.spi_read_n; b_a = bus.spi_mem_addr;
                    b_d = bus.spi_data_from_cpu; b_ok = bus.spi_read_n ^ bus.spi_write_n;
                end else begin
                    b_len++;
                    b_ok = b_ok && (bus.spi_read_n ^ bus.spi_write_n) && ((!bus.spi_read_n) == b_rd) &&
                           (bus.spi_mem_addr == b_a) && (bus.spi_data_from_cpu == b_d);
                end
            end else begin
                if (!(bus.spi_read_n && bus.spi_write_n)) idle_bad = 1'b1;
                if (b_prev_sel) begin
                    if (exp_acc.size() == 0) begin
                        check(1'b0, "access", $sformatf("unexpected rd=%0d a=%0d d=%h", b_rd, b_a, b_d));
                    end else begin
                        e = exp_acc.pop_front();
                        check(b_ok && b_len == 2 && b_rd == e.rd && b_a == e.a && (e.rd || b_d == e.d), "access",
                              $sformatf("got len=%0d stable=%0d rd=%0d a=%0d d=%h, want len=2 rd=%0d a=%0d d=%h",
                                        b_len, b_ok, b_rd, b_a, b_d, e.rd, e.a, e.d));
                    end
                end
            end
            b_prev_sel = bus.spi_select;

            if (bus.req_ack != 2'b00) begin
                g = (exp_grant.size() != 0) ? exp_grant.pop_front() : 1'b0;
                check(a_prev == 2'b00 && bus.req_ack == (g ? 2'b10 : 2'b01), "grant",
                      $sformatf("got req_ack=%b prev=%b, want %b for one cycle", bus.req_ack, a_prev, g ? 2'b10 : 2'b01));
                ack_cyc = cyc;
                n_acks++;
            end
            a_prev = bus.req_ack;

            if (bus.rsp_valid) begin
                n_rsp++;
                if (exp_rsp.size() == 0) begin
                    check(1'b0, "rsp", $sformatf("unexpected rsp id=%0d rdata=%h err=%0d", bus.rsp_id, bus.rsp_rdata, bus.rsp_err));
                end else begin
                    r = exp_rsp.pop_front();
                    check(bus.rsp_id == r.id && bus.rsp_rdata == r.rdata && bus.rsp_err == r.err && bus.busy &&
                          (cyc - ack_cyc) <= 120, "rsp",
                          $sformatf("got id=%0d rdata=%h err=%0d busy=%0d lat=%0d, want id=%0d rdata=%h err=%0d busy=1 lat<=120",
                                    bus.rsp_id, bus.rsp_rdata, bus.rsp_err, bus.busy, cyc - ack_cyc, r.id, r.rdata, r.err));
                end
            end
        end
    end

    task automatic push_acc(input bit rd, input logic [2:0] a, input logic [15:0] d);
        acc_t e;
        e.rd = rd; e.a = a; e.d = d;
        exp_acc.push_back(e);
    endtask

    // b0..b2 are the hand-computed MOSI bytes; abort_byte < 3 stalls RX on that byte
    task automatic push_txn(input bit id, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] rdata, input int abort_byte);
        rsp_t r;
        logic [7:0] bytes [3];
        bytes[0] = b0; bytes[1] = b1; bytes[2] = b2;
        exp_grant.push_back(id);
        push_acc(1'b0, 3'd5, 16'h0001);
        push_acc(1'b0, 3'd3, 16'h0400);
        r.id = id; r.rdata = rdata; r.err = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_acc(1'b0, 3'd1, {8'h00, bytes[i]});
            if (i == abort_byte) begin
                push_acc(1'b0, 3'd2, 16'h0000);
                r.rdata = 8'h00; r.err = 1'b1;
                break;
            end
            push_acc(1'b1, 3'd0, 16'h0000);
        end
        push_acc(1'b0, 3'd3, 16'h0000);
        exp_rsp.push_back(r);
    endtask

    task automatic set_req(input bit id, input bit wr, input logic [9:0] addr, input logic [7:0] wd);
        bus.req_write[id] = wr;
        if (id) begin bus.req_addr[19:10] = addr; bus.req_wdata[15:8] = wd; end
        else    begin bus.req_addr[9:0]   = addr; bus.req_wdata[7:0]  = wd; end
    endtask

    task automatic issue(input bit id);
        bit seen = 1'b0;
        bus.req_valid[id] = 1'b1;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (bus.req_ack[id]) seen = 1'b1;
        end
        bus.req_valid[id] = 1'b0;
        if (!seen) check(1'b0, "ack_timeout", $sformatf("no req_ack for id %0d in 50 cycles", id));
    endtask

    task automatic wait_done(input int budget);
        int i = 0;
        while (exp_rsp.size() != 0 && i < budget) begin @(negedge clk); i++; end
        if (exp_rsp.size() != 0) check(1'b0, "done_timeout", $sformatf("%0d responses outstanding after %0d cycles", exp_rsp.size(), budget));
        repeat (2) @(negedge clk);
    endtask

    function automatic bit outputs_at_reset();
        return bus.req_ack == 2'b00 && !bus.rsp_valid && !bus.rsp_id && bus.rsp_rdata == 8'h00 && !bus.rsp_err &&
               !bus.busy && !bus.spi_select && bus.spi_read_n && bus.spi_write_n && bus.spi_mem_addr == 3'd0 &&
               bus.spi_data_from_cpu == 16'h0000;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks0, rsp0;
        bus.req_valid = 2'b00; bus.req_write = 2'b00; bus.req_addr = 20'h0; bus.req_wdata = 16'h0;
        repeat (3) @(negedge clk);
        check(outputs_at_reset(), "reset_values", $sformatf("ack=%b sel=%0d rd_n=%0d wr_n=%0d busy=%0d",
              bus.req_ack, bus.spi_select, bus.spi_read_n, bus.spi_write_n, bus.busy));
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // arbitration: both held, expect 0,1,0
        set_req(1'b0, 1'b1, 10'h155, 8'h3C);
        set_req(1'b1, 1'b0, 10'h001, 8'h00);
        push_txn(1'b0, 8'h81, 8'h55, 8'h3C, 8'h00, 3);
        push_txn(1'b1, 8'h00, 8'h01, 8'h00, 8'h5C, 3);
        push_txn(1'b0, 8'h81, 8'h55, 8'h3C, 8'h00, 3);
        acks0 = n_acks;
        bus.req_valid = 2'b11;
        for (int i = 0; i < 400 && (n_acks - acks0) < 3; i++) @(negedge clk);
        bus.req_valid = 2'b00;
        check((n_acks - acks0) == 3, "arb_acks", $sformatf("got %0d grants, want 3", n_acks - acks0));
        wait_done(300);

        // write 0x037 = 0xA5
        set_req(1'b0, 1'b1, 10'h037, 8'hA5);
        push_txn(1'b0, 8'h80, 8'h37, 8'hA5, 8'h00, 3);
        issue(1'b0);
        wait_done(200);

        // read 0x2AB, slave returns 0x5C
        miso2 = 8'h5C;
        set_req(1'b1, 1'b0, 10'h2AB, 8'h00);
        push_txn(1'b1, 8'h02, 8'hAB, 8'h00, 8'h5C, 3);
        issue(1'b1);
        wait_done(200);

        // timeout on byte 1 receive
        stall_byte = 1;
        set_req(1'b0, 1'b0, 10'h100, 8'h00);
        push_txn(1'b0, 8'h01, 8'h00, 8'h00, 8'h00, 1);
        issue(1'b0);
        wait_done(200);
        check(w2_cyc - w1_cyc[1] == 19, "timeout_len", $sformatf("abort access %0d cycles after byte1 write, want 19", w2_cyc - w1_cyc[1]));
        check(sso_reg == 16'h0000, "sso_released", $sformatf("sso=%h, want 0000", sso_reg));
        stall_byte = 3;

        // reset while byte 1 shifts
        set_req(1'b0, 1'b1, 10'h0FF, 8'h77);
        push_txn(1'b0, 8'h80, 8'hFF, 8'h77, 8'h00, 3);
        issue(1'b0);
        for (int i = 0; i < 100 && byte_n < 2; i++) @(negedge clk);
        check(byte_n == 2, "reach_byte1", $sformatf("byte count %0d, want 2", byte_n));
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check(outputs_at_reset(), "midreset_values", $sformatf("ack=%b sel=%0d rd_n=%0d wr_n=%0d busy=%0d rsp_valid=%0d",
              bus.req_ack, bus.spi_select, bus.spi_read_n, bus.spi_write_n, bus.busy, bus.rsp_valid));
        exp_acc.delete(); exp_rsp.delete(); exp_grant.delete();
        rsp0 = n_rsp;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        check(n_rsp == rsp0, "no_rsp_after_reset", $sformatf("%0d responses, want 0", n_rsp - rsp0));

        set_req(1'b0, 1'b1, 10'h3C2, 8'h12);
        push_txn(1'b0, 8'h83, 8'hC2, 8'h12, 8'h00, 3);
        issue(1'b0);
        wait_done(200);

        check(exp_acc.size() == 0 && exp_grant.size() == 0, "queues_drained",
              $sformatf("accesses=%0d grants=%0d left, want 0", exp_acc.size(), exp_grant.size()));
        check(!idle_bad, "idle_strobes", $sformatf("strobe active without select=%0d, want 0", idle_bad));
        check(!bus.busy, "idle_busy", $sformatf("busy=%0d, want 0", bus.busy));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/ad9361_spi_sequencer.md
# ad9361_spi_sequencer

Sequences complete AD9361 register transactions over the 8-bit SPI master core (CPOL=1, CPHA=0, MSB first, sys_clk/2 SCLK, one slave). The block arbitrates round-robin between two requesters. For each granted request it drives the core's register port: slave-select, SSO, three data bytes, three receive reads, then SSO release. It sits between fabric requesters (NIOS bridge, RF gain/tuning engines) and the SPI core instance.

## Interface
- `TIMEOUT_CYCLES`, default 255: max cycles in any wait state before abort; 8-bit counter, legal range 2..255.
- `SS_MASK`, default 16'h0001: value written to the core slave-select register.

- `clk`  in  1  system clock; same clock as the SPI core.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  2  per-requester request; held with its fields until `req_ack`.
- `req_write`  in  2  1 = register write, 0 = register read.
- `req_addr`  in  20  {req1[9:0], req0[9:0]} AD9361 register address.
- `req_wdata`  in  16  {req1[7:0], req0[7:0]} write data.
- `req_ack`  out  2  one-cycle grant pulse; requester may drop `valid` next cycle.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_id`  out  1  requester of the completed transaction.
- `rsp_rdata`  out  8  read byte; 0 for writes and errors.
- `rsp_err`  out  1  timeout abort.
- `busy`  out  1  high from ack through rsp_valid.
- `spi_select`, `spi_read_n`, `spi_write_n`  out  1 each  core port strobes.
- `spi_mem_addr`  out  3  core register address.
- `spi_data_from_cpu`  out  16  core write data.
- `spi_data_to_cpu`  in  16  core read data.
- `spi_readyfordata`  in  1  core TRDY.
- `spi_dataavailable`  in  1  core RRDY.

Reset values: all `req_ack`, `rsp_*` and `busy` = 0; `spi_select` = 0; `spi_read_n` = `spi_write_n` = 1; `spi_mem_addr` = 0; `spi_data_from_cpu` = 0.

## Operation
- **Arbitration:** evaluated only in IDLE. A lone valid wins. On a tie, the requester not granted last wins. The last-grant pointer resets to 1, so req0 wins the first tie. Latch id/write/addr/wdata at the same edge `req_ack` pulses.
- **Instruction word:** {write, 3'b000, 2'b00, addr[9:0]}.
  - Byte0 = instr[15:8].
  - Byte1 = instr[7:0].
  - Byte2 = wdata for writes, 8'h00 for reads.
- **FSM:** IDLE → SEL (wr addr5 = SS_MASK) → SSO_ON (wr addr3 = 16'h0400) → per byte i = 0..2: WAIT_TX (readyfordata) → WR_DATA (wr addr1 = {8'h00, byte_i}) → WAIT_RX (dataavailable) → RD_DATA (rd addr0; capture [7:0]) → after byte 2: SSO_OFF (wr addr3 = 16'h0000) → RESP → IDLE.
- **Response:** `rsp_rdata` = captured byte 2 for reads, 0 for writes. Every received byte is read, so the core never flags ROE.
- **Timeout:** an 8-bit counter clears on entry to each WAIT state and increments each cycle while waiting. When it reaches TIMEOUT_CYCLES, go to ABORT: wr addr2 = 0 (clears status), then SSO_OFF, then RESP with `rsp_err` = 1 and `rsp_rdata` = 0.
- **Reset mid-transaction:** immediate return to IDLE with all outputs at reset values. No response is issued for the lost request.

## Timing
- **Bus access:** `spi_select`, `spi_mem_addr`, `spi_data_from_cpu` and the active strobe (`spi_write_n` = 0 or `spi_read_n` = 0) are held exactly 2 cycles. Then 1 gap cycle follows with `spi_select` = 0 and both strobes = 1. No back-to-back accesses.
- **Read capture:** `spi_data_to_cpu` is captured at the edge ending the 2nd access cycle.
- **Status sampling:** WAIT states sample `spi_readyfordata` / `spi_dataavailable` only after the gap cycle. Exit on the first cycle sampled high; the next access starts the following cycle.
- **Pulse timing:**
  - `req_ack` pulses the cycle after valid is seen in IDLE.
  - `rsp_valid` pulses 1 cycle after the SSO_OFF gap.
  - The next grant occurs no earlier than the cycle after `rsp_valid`.
- **Access count:** 9 bus accesses per transaction (27 bus cycles) plus SPI shift time. With the core at sys_clk/2, a nominal transaction completes within 120 cycles of `req_ack`.

## Test plan
- **Write:** req0 write, addr 0x037, data 0xA5. Required core port sequence: wr5 = 0x0001, wr3 = 0x0400, wr1 = 0x80/0x37/0xA5 interleaved with three rd0, then wr3 = 0x0000. MOSI carries 80 37 A5. Response: `rsp_valid`, id 0, err 0, rdata 0x00, within 120 cycles.
- **Read:** req1 read, addr 0x2AB; SPI slave model returns 0x5C in byte 2. Required: MOSI carries 02 AB 00; `rsp_rdata` = 0x5C, id 1.
- **Arbitration:** both valid and held across three transactions after reset. Required: grant order 0, 1, 0; each `req_ack` is exactly 1 cycle.
- **Timeout:** TIMEOUT_CYCLES = 16; core model forces `dataavailable` = 0 on byte 1. Required: abort after 16 wait cycles, wr2 then wr3 = 0x0000, `rsp_err` = 1, rdata 0, SS_n high.
- **Bus protocol:** monitor across all scenarios. Required: every strobe is 2 cycles followed by ≥1 idle cycle; no write to addr1 while `readyfordata` = 0 (core TOE stays 0).
- **Reset mid-transaction:** assert `reset_n` during byte 1 shifting. Required: all outputs at reset values immediately, no `rsp_valid`. After release, a req0 write completes normally.
